// File: rtl/l1d_ld_arb.sv
// l1d_ld_arb -- load-request arbiter in front of the L1D load port.
//
// Arbitrates REQ_N load requesters (index 0 is the replay path) onto one L1D
// load port, tracks which lsu_ids are in flight and steers each final
// response back to the requester that issued that id.
//
// Parameters
//   REQ_N      number of requesters
//   ID_W       lsu_id width (2**ID_W ids)
//   STARVE_LIM wait-cycle threshold for the starvation override
//   PLD_W      payload width, {lsu_id[ID_W], type[6], addr[56], cacheable[1]}
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   req_valid_i/req_i    per-requester request; requester r payload at
//                        req_i[r*PLD_W +: PLD_W]
//   req_ready_o          per-requester accept (one-hot or zero)
//   l1d_req_valid_o/l1d_req_o/l1d_req_ready_i   L1D load request channel
//   l1d_resp_valid_i/l1d_resp_id_i              final L1D load response
//   resp_valid_o         one-hot response steering to the owning requester
//   outstanding_cnt_o    registered count of in-flight ids
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once l1d_req_valid_o is raised and not accepted, the grant is locked
// to that requester, which keeps its payload stable; if it drops its valid the
// lock is released and normal arbitration applies in that same cycle.
//
// Build option: define L1D_LD_ARB_STARVE_EN to build per-requester wait
// counters; an unlocked grant then goes to the lowest-index eligible requester
// whose counter has reached STARVE_LIM. Without it arbitration is pure
// round-robin and no counters exist.
module l1d_ld_arb #(
  parameter int REQ_N      = 3,
  parameter int ID_W       = 5,
  parameter int STARVE_LIM = 8,
  localparam int PLD_W     = ID_W + 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_N-1:0]         req_valid_i,
  input  logic [REQ_N*PLD_W-1:0]   req_i,
  output logic [REQ_N-1:0]         req_ready_o,
  output logic                     l1d_req_valid_o,
  output logic [PLD_W-1:0]         l1d_req_o,
  input  logic                     l1d_req_ready_i,
  input  logic                     l1d_resp_valid_i,
  input  logic [ID_W-1:0]          l1d_resp_id_i,
  output logic [REQ_N-1:0]         resp_valid_o,
  output logic [ID_W:0]            outstanding_cnt_o
);

  localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int NID   = 1 << ID_W;

  if (STARVE_LIM < 1) begin : g_bad_cfg
    $error("l1d_ld_arb: STARVE_LIM must be at least 1");
  end

  logic [ID_W-1:0]  req_id [REQ_N];
  logic [REQ_N-1:0] eligible;
  logic [NID-1:0]   inflight_q;
  logic [IDX_W-1:0] owner_q [NID];
  logic [IDX_W-1:0] rr_ptr_q;
  logic             lock_v_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [ID_W:0]    out_cnt_q;

  logic             grant_v;
  logic [IDX_W-1:0] grant_idx;
  logic [ID_W-1:0]  grant_id;
  logic             accept;
  logic             resp_hit;
  int               cand;

`ifdef L1D_LD_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  logic [CNT_W-1:0] wait_cnt_q [REQ_N];
`endif

  // An id already in flight must not be issued again until its response.
  always_comb begin
    for (int r = 0; r < REQ_N; r++) begin
      req_id[r]   = req_i[r*PLD_W + PLD_W - ID_W +: ID_W];
      eligible[r] = req_valid_i[r] & ~inflight_q[req_id[r]];
    end
  end

  // Both search loops run from the highest candidate down so the last
  // assignment wins: round-robin first, then the starvation override.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (lock_v_q && req_valid_i[lock_idx_q]) begin
      grant_v   = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int k = REQ_N - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr_q) + k) % REQ_N;
        if (eligible[cand]) begin
          grant_v   = 1'b1;
          grant_idx = IDX_W'(cand);
        end
      end
`ifdef L1D_LD_ARB_STARVE_EN
      for (int r = REQ_N - 1; r >= 0; r--) begin
        if (eligible[r] && wait_cnt_q[r] == CNT_W'(STARVE_LIM)) begin
          grant_v   = 1'b1;
          grant_idx = IDX_W'(r);
        end
      end
`endif
    end
  end

  always_comb begin
    grant_id        = req_id[grant_idx];
    accept          = grant_v & l1d_req_ready_i;
    l1d_req_valid_o = grant_v;
    l1d_req_o       = grant_v ? req_i[int'(grant_idx)*PLD_W +: PLD_W] : '0;
    req_ready_o     = accept ? (REQ_N'(1) << grant_idx) : '0;
    resp_hit        = l1d_resp_valid_i & inflight_q[l1d_resp_id_i];
    resp_valid_o    = resp_hit ? (REQ_N'(1) << owner_q[l1d_resp_id_i]) : '0;
  end

  assign outstanding_cnt_o = out_cnt_q;

  // An accept and a response never hit the same id in one cycle (eligibility
  // uses inflight_q), so the two bit updates below never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      rr_ptr_q   <= '0;
      lock_v_q   <= 1'b0;
      lock_idx_q <= '0;
      out_cnt_q  <= '0;
      for (int i = 0; i < NID; i++) owner_q[i] <= '0;
    end else begin
      if (resp_hit) inflight_q[l1d_resp_id_i] <= 1'b0;
      if (accept) begin
        inflight_q[grant_id] <= 1'b1;
        owner_q[grant_id]    <= grant_idx;
        rr_ptr_q             <= (grant_idx == IDX_W'(REQ_N - 1)) ? '0 : grant_idx + 1'b1;
      end
      lock_v_q   <= grant_v & ~l1d_req_ready_i;
      lock_idx_q <= grant_idx;
      case ({accept, resp_hit})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

`ifdef L1D_LD_ARB_STARVE_EN
  // Counts cycles a requester was eligible but lost; an ineligible
  // (id-blocked) requester holds its count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REQ_N; r++) wait_cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < REQ_N; r++) begin
        if (!req_valid_i[r] || (accept && grant_idx == IDX_W'(r)))
          wait_cnt_q[r] <= '0;
        else if (eligible[r] && wait_cnt_q[r] != CNT_W'(STARVE_LIM))
          wait_cnt_q[r] <= wait_cnt_q[r] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1d_ld_arb.sv
// tb_l1d_ld_arb -- directed bench for l1d_ld_arb (REQ_N=3, ID_W=5,
// STARVE_LIM=2). Expected grants are queued when stimulus is driven and
// popped when the arbiter presents a request; a small id/owner model gives
// the expected response steering and outstanding count.
module tb_l1d_ld_arb;
  localparam int REQ_N = 3;
  localparam int ID_W  = 5;
  localparam int PLD_W = ID_W + 63;
  localparam int W     = PLD_W + REQ_N;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [REQ_N-1:0]       req_valid_i;
  logic [REQ_N*PLD_W-1:0] req_i;
  logic [REQ_N-1:0]       req_ready_o;
  logic                   l1d_req_valid_o;
  logic [PLD_W-1:0]       l1d_req_o;
  logic                   l1d_req_ready_i;
  logic                   l1d_resp_valid_i;
  logic [ID_W-1:0]        l1d_resp_id_i;
  logic [REQ_N-1:0]       resp_valid_o;
  logic [ID_W:0]          outstanding_cnt_o;

  l1d_ld_arb #(.REQ_N(REQ_N), .ID_W(ID_W), .STARVE_LIM(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_i(req_i), .req_ready_o(req_ready_o),
    .l1d_req_valid_o(l1d_req_valid_o), .l1d_req_o(l1d_req_o),
    .l1d_req_ready_i(l1d_req_ready_i),
    .l1d_resp_valid_i(l1d_resp_valid_i), .l1d_resp_id_i(l1d_resp_id_i),
    .resp_valid_o(resp_valid_o), .outstanding_cnt_o(outstanding_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [W-1:0]     exp_q[$];
  logic             inflight_m [32];
  logic [1:0]       owner_m [32];
  int               exp_out;
  logic [REQ_N-1:0] exp_resp;
  logic             pend_acc, pend_rsp;
  int               pend_acc_id, pend_acc_r, pend_rsp_id;
  int               n_cmp, n_bad;

  function automatic logic [PLD_W-1:0] mk(input int r, input int id);
    logic [55:0] addr;
    addr = 56'h12_3400_0000 + 56'(id * 64 + r * 8);
    return {ID_W'(id), 6'(r + 1), addr, 1'(r % 2)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int r, input logic v, input int id);
    req_valid_i[r] = v;
    req_i[r*PLD_W +: PLD_W] = mk(r, id);
  endtask

  task automatic exp_grant(input int r, input int id, input logic acc);
    logic [REQ_N-1:0] rdy;
    rdy = acc ? (REQ_N'(1) << r) : '0;
    exp_q.push_back({rdy, mk(r, id)});
    if (acc) begin
      pend_acc    = 1'b1;
      pend_acc_id = id;
      pend_acc_r  = r;
    end
  endtask

  task automatic resp_set(input int id);
    l1d_resp_valid_i = 1'b1;
    l1d_resp_id_i    = ID_W'(id);
    if (inflight_m[id]) begin
      exp_resp    = REQ_N'(1) << owner_m[id];
      pend_rsp    = 1'b1;
      pend_rsp_id = id;
    end else begin
      exp_resp = '0;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_acc) begin
      inflight_m[pend_acc_id] = 1'b1;
      owner_m[pend_acc_id]    = 2'(pend_acc_r);
      exp_out++;
      pend_acc = 1'b0;
    end
    if (pend_rsp) begin
      inflight_m[pend_rsp_id] = 1'b0;
      exp_out--;
      pend_rsp = 1'b0;
    end
    l1d_resp_valid_i = 1'b0;
    exp_resp = '0;
  endtask

  task automatic chk_grant(input string tag);
    logic [W-1:0] e;
    chk({tag, "_vld"}, 128'(l1d_req_valid_o), 128'(1'b1));
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed grant expected none queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 128'({req_ready_o, l1d_req_o}), 128'(e));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, 128'(l1d_req_valid_o), 128'(1'b0));
    chk({tag, "_rdy"}, 128'(req_ready_o), 128'(3'b000));
  endtask

  task automatic chk_resp(input string tag);
    chk(tag, 128'(resp_valid_o), 128'(exp_resp));
  endtask

  task automatic chk_out(input string tag);
    chk(tag, 128'(outstanding_cnt_o), 128'(exp_out));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_ids[5];
    rr_ids = '{1, 2, 4, 8, 9};
    n_cmp = 0; n_bad = 0; exp_out = 0; exp_resp = '0;
    pend_acc = 1'b0; pend_rsp = 1'b0;
    pend_acc_id = 0; pend_acc_r = 0; pend_rsp_id = 0;
    for (int i = 0; i < 32; i++) begin inflight_m[i] = 1'b0; owner_m[i] = '0; end
    rst = 1'b1; req_valid_i = '0; req_i = '0; l1d_req_ready_i = 1'b0;
    l1d_resp_valid_i = 1'b0; l1d_resp_id_i = '0;

    // reset state
    tick(); tick();
    settle();
    chk_out("rst0_cnt"); chk_idle("rst0"); chk_resp("rst0_resp");
    rst = 1'b0;
    tick();

    // round robin 0,1,2,0,1 with ready held high
    l1d_req_ready_i = 1'b1;
    drive(0, 1, 1); drive(1, 1, 2); drive(2, 1, 4);
    exp_grant(0, 1, 1); settle(); chk_grant("rr_c1"); tick();
    drive(0, 1, 8); exp_grant(1, 2, 1); settle(); chk_grant("rr_c2"); chk_out("rr_cnt1"); tick();
    drive(1, 1, 9); exp_grant(2, 4, 1); settle(); chk_grant("rr_c3"); tick();
    drive(2, 0, 4); exp_grant(0, 8, 1); settle(); chk_grant("rr_c4"); chk_out("rr_cnt3"); tick();
    drive(0, 0, 8); exp_grant(1, 9, 1); settle(); chk_grant("rr_c5"); tick();
    drive(1, 0, 9); settle(); chk_idle("rr_idle"); chk_out("rr_cnt5");
    for (int i = 0; i < 5; i++) begin
      resp_set(rr_ids[i]); settle(); chk_resp("rr_rsp"); tick();
    end
    settle(); chk_out("rr_cnt0");

    // lock: req 1 stalled, req 0 arrives behind it
    l1d_req_ready_i = 1'b0;
    drive(1, 1, 11); exp_grant(1, 11, 0); settle(); chk_grant("lock_c1"); tick();
    drive(0, 1, 12);
    for (int i = 0; i < 4; i++) begin
      exp_grant(1, 11, 0); settle(); chk_grant("lock_hold"); tick();
    end
    l1d_req_ready_i = 1'b1;
    exp_grant(1, 11, 1); settle(); chk_grant("lock_acc"); tick();
    drive(1, 0, 11); exp_grant(0, 12, 1); settle(); chk_grant("after_lock"); tick();

    // lock released when the locked requester drops valid
    drive(0, 0, 12); drive(2, 1, 14); l1d_req_ready_i = 1'b0;
    exp_grant(2, 14, 0); settle(); chk_grant("rel_c1"); tick();
    drive(2, 0, 14); drive(1, 1, 15); drive(0, 1, 16); l1d_req_ready_i = 1'b1;
    exp_grant(1, 15, 1); settle(); chk_grant("rel_c2"); tick();
    drive(0, 0, 16); drive(1, 0, 15);

    // id 7 in flight blocks req 2 until its response
    drive(0, 1, 7); exp_grant(0, 7, 1); settle(); chk_grant("id7_acc"); tick();
    drive(0, 0, 7); drive(2, 1, 7);
    for (int i = 0; i < 3; i++) begin
      settle(); chk_idle("id7_blk"); chk_resp("id7_blk_resp"); tick();
    end
    resp_set(7); settle(); chk_resp("id7_rsp"); chk_idle("id7_blk_rsp"); tick();
    exp_grant(2, 7, 1); resp_set(11); settle();
    chk_grant("id7_regrant"); chk_resp("acc_rsp_same"); tick();
    drive(2, 0, 7); settle(); chk_out("acc_rsp_cnt");
    resp_set(11); settle(); chk_resp("rsp11_drop"); tick();

    // response steering and duplicate drop
    drive(1, 1, 3); exp_grant(1, 3, 1); settle(); chk_grant("id3_acc"); tick();
    drive(1, 0, 3);
    resp_set(3); settle(); chk_resp("id3_rsp"); tick();
    resp_set(3); settle(); chk_resp("id3_dup"); tick();
    settle(); chk_out("id3_cnt");

    // starvation: req 2 waits behind a lock while round-robin points at 1
    drive(2, 1, 20); exp_grant(2, 20, 1); settle(); chk_grant("stv_pre"); tick();
    drive(2, 1, 21); drive(0, 1, 22); l1d_req_ready_i = 1'b0;
    exp_grant(0, 22, 0); settle(); chk_grant("stv_a"); tick();
    exp_grant(0, 22, 0); settle(); chk_grant("stv_b"); tick();
    l1d_req_ready_i = 1'b1; drive(1, 1, 23);
    exp_grant(0, 22, 1); settle(); chk_grant("stv_c"); tick();
    drive(0, 0, 22);
`ifdef L1D_LD_ARB_STARVE_EN
    exp_grant(2, 21, 1);
`else
    exp_grant(1, 23, 1);
`endif
    settle(); chk_grant("stv_d"); tick();
    drive(0, 0, 22); drive(1, 0, 23); drive(2, 0, 21);
    settle(); chk_out("stv_cnt");

    // reset mid-operation discards tracking
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) inflight_m[i] = 1'b0;
    exp_out = 0;
    settle(); chk_out("rst_cnt"); chk_idle("rst_idle");
    rst = 1'b0;
    tick();
    resp_set(12); settle(); chk_resp("rst_rsp12"); tick();
    resp_set(15); settle(); chk_resp("rst_rsp15"); tick();
    settle(); chk_out("rst_cnt2");

    // fill all 32 ids, then drain
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, i); exp_grant(0, i, 1); settle(); chk_grant("fill"); tick();
    end
    drive(0, 1, 5); settle(); chk_out("fill_32"); chk_idle("fill_blk");
    drive(0, 0, 5);
    for (int i = 0; i < 32; i++) begin
      resp_set(i); settle(); chk_resp("drain"); tick();
    end
    settle(); chk_out("drain_0");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
